// File: rtl/multicycle_controller_if.sv
// Control and handshake bundle between the multi-cycle controller and the MIPS
// datapath / instruction memory / data memory.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr_in;
    logic             imem_ready;
    logic             dmem_ready;
    logic             br_cond;
    logic             imem_req;
    logic             ir_we;
    logic             pc_we;
    logic             dmem_req;
    logic             MemWrite;
    logic             RegWrite;
    logic [4:0]       RegAddr;
    logic [2:0]       ALUControl;
    logic             ALUSrc;
    logic [2:0]       EXTControl;
    logic [2:0]       Mem2Reg;
    logic [2:0]       NPCControl;
    logic [1:0]       md_start;
    logic             md_busy;
    logic             illegal;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  instr_in, imem_ready, dmem_ready, br_cond,
        output imem_req, ir_we, pc_we, dmem_req, MemWrite, RegWrite, RegAddr,
               ALUControl, ALUSrc, EXTControl, Mem2Reg, NPCControl,
               md_start, md_busy, illegal, instr_retired
    );

    modport slave (
        output instr_in, imem_ready, dmem_ready, br_cond,
        input  imem_req, ir_we, pc_we, dmem_req, MemWrite, RegWrite, RegAddr,
               ALUControl, ALUSrc, EXTControl, Mem2Reg, NPCControl,
               md_start, md_busy, illegal, instr_retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: registers the instruction, decodes it once and
// sequences FETCH/DECODE/EXEC/MEM/WB/MDWAIT with memory and mult/div stalls.
module multicycle_controller #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 9,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MD_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_XOR = 3'b010,
                           ALU_OR  = 3'b011, ALU_SLL = 3'b100;
    localparam logic [2:0] EXT_ZERO = 3'b000, EXT_SIGN = 3'b001, EXT_LUI = 3'b010;
    localparam logic [2:0] M2R_ALU  = 3'b000, M2R_WORD = 3'b001, M2R_LUI = 3'b010,
                           M2R_LINK = 3'b011, M2R_BYTE = 3'b100, M2R_HI  = 3'b101,
                           M2R_LO   = 3'b110;
    localparam logic [2:0] NPC_SEQ = 3'b000, NPC_BR = 3'b001, NPC_JMP = 3'b010,
                           NPC_REG = 3'b100;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MDWAIT
    } state_t;

    typedef enum logic [2:0] {
        K_WB, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_JREG, K_MULT, K_DIV
    } kind_t;

    state_t            state, state_nxt;
    logic [31:0]       ir;
    logic [MD_W-1:0]   md_cnt;
    logic [CNT_W-1:0]  retired;

    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    logic       legal, link;
    kind_t      kind;

    assign op = ir[31:26];
    assign fn = ir[5:0];
    assign rt = ir[20:16];
    assign rd = ir[15:11];

    // rs and shamt are consumed by the datapath directly, never by control.
    logic unused_ir;
    assign unused_ir = ^{ir[25:21], ir[10:6]};

    // Instruction decode, purely from the registered IR.
    always_comb begin
        legal          = 1'b1;
        link           = 1'b0;
        kind           = K_WB;
        bus.ALUControl = ALU_ADD;
        bus.ALUSrc     = 1'b0;
        bus.EXTControl = EXT_ZERO;
        bus.Mem2Reg    = M2R_ALU;
        bus.RegAddr    = rt;
        case (op)
            6'b000000: begin
                bus.RegAddr = rd;
                case (fn)
                    6'b100000: bus.ALUControl = ALU_ADD;
                    6'b100010: bus.ALUControl = ALU_SUB;
                    6'b100110: bus.ALUControl = ALU_XOR;
                    6'b000000: bus.ALUControl = ALU_SLL;
                    6'b001000: kind = K_JREG;
                    6'b001001: begin
                        kind        = K_JREG;
                        link        = 1'b1;
                        bus.Mem2Reg = M2R_LINK;
                    end
                    6'b011000: kind = K_MULT;
                    6'b011010: kind = K_DIV;
                    6'b010000: bus.Mem2Reg = M2R_HI;
                    6'b010010: bus.Mem2Reg = M2R_LO;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001101: begin
                bus.ALUControl = ALU_OR;
                bus.ALUSrc     = 1'b1;
            end
            6'b001000: begin
                bus.ALUSrc     = 1'b1;
                bus.EXTControl = EXT_SIGN;
            end
            6'b100011: begin
                kind           = K_LOAD;
                bus.ALUSrc     = 1'b1;
                bus.EXTControl = EXT_SIGN;
                bus.Mem2Reg    = M2R_WORD;
            end
            6'b100000: begin
                kind           = K_LOAD;
                bus.ALUSrc     = 1'b1;
                bus.EXTControl = EXT_SIGN;
                bus.Mem2Reg    = M2R_BYTE;
            end
            6'b101011: begin
                kind           = K_STORE;
                bus.ALUSrc     = 1'b1;
                bus.EXTControl = EXT_SIGN;
            end
            6'b000100: begin
                kind           = K_BRANCH;
                bus.ALUControl = ALU_SUB;
                bus.EXTControl = EXT_SIGN;
            end
            6'b000111: begin
                kind           = K_BRANCH;
                bus.EXTControl = EXT_SIGN;
            end
            6'b001111: begin
                bus.ALUSrc     = 1'b1;
                bus.EXTControl = EXT_LUI;
                bus.Mem2Reg    = M2R_LUI;
            end
            6'b000010: kind = K_JUMP;
            6'b000011: begin
                kind        = K_JUMP;
                link        = 1'b1;
                bus.Mem2Reg = M2R_LINK;
                bus.RegAddr = 5'd31;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (kind)
            K_BRANCH: bus.NPCControl = bus.br_cond ? NPC_BR : NPC_SEQ;
            K_JUMP:   bus.NPCControl = NPC_JMP;
            K_JREG:   bus.NPCControl = NPC_REG;
            default:  bus.NPCControl = NPC_SEQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.md_start = 2'b00;
        bus.md_busy  = 1'b0;
        bus.illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_we = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    bus.illegal = 1'b1;
                    bus.pc_we   = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind)
                    K_WB:              state_nxt = S_WB;
                    K_LOAD, K_STORE:   state_nxt = S_MEM;
                    K_BRANCH, K_JUMP, K_JREG: begin
                        bus.pc_we    = 1'b1;
                        bus.RegWrite = link;
                        state_nxt    = S_FETCH;
                    end
                    K_MULT: begin
                        bus.md_start = 2'b01;
                        state_nxt    = S_MDWAIT;
                    end
                    K_DIV: begin
                        bus.md_start = 2'b10;
                        state_nxt    = S_MDWAIT;
                    end
                endcase
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.MemWrite = (kind == K_STORE);
                if (bus.dmem_ready) begin
                    if (kind == K_STORE) begin
                        bus.pc_we = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.pc_we    = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MDWAIT: begin
                bus.md_busy = 1'b1;
                if (md_cnt == '0) begin
                    bus.pc_we = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Loaded with LAT-1 so MDWAIT lasts exactly LAT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir      <= '0;
            md_cnt  <= '0;
            retired <= '0;
        end else begin
            if (bus.ir_we) ir <= bus.instr_in;
            if (state == S_EXEC && kind == K_MULT)      md_cnt <= MD_W'(MULT_LAT - 1);
            else if (state == S_EXEC && kind == K_DIV)  md_cnt <= MD_W'(DIV_LAT - 1);
            else if (state == S_MDWAIT && md_cnt != '0) md_cnt <= md_cnt - 1'b1;
            if (bus.pc_we) retired <= retired + 1'b1;
        end
    end

    assign bus.instr_retired = retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle enable vectors and decoded
// fields are compared against hand-computed constants.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(3)) bus();

    multicycle_controller #(.MULT_LAT(4), .DIV_LAT(9), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // {imem_req, ir_we, pc_we, dmem_req, MemWrite, RegWrite, md_busy, illegal, md_start}
    logic [9:0] ens;
    assign ens = {bus.imem_req, bus.ir_we, bus.pc_we, bus.dmem_req, bus.MemWrite,
                  bus.RegWrite, bus.md_busy, bus.illegal, bus.md_start};

    localparam logic [9:0] E_FR = 10'h300, E_FW = 10'h200, E_NONE = 10'h000,
                           E_ILL = 10'h084, E_PC = 10'h080, E_WB = 10'h090,
                           E_MR = 10'h040, E_MW = 10'h060, E_SWR = 10'h0E0,
                           E_MUL = 10'h001, E_DIV = 10'h002, E_BUSY = 10'h008,
                           E_BDONE = 10'h088;

    localparam logic [31:0] ORI  = 32'h3425_1234, LW   = 32'h8C47_0004,
                            BEQ  = 32'h1022_0003, BGTZ = 32'h1C60_0002,
                            MULT = 32'h0085_0018, MFHI = 32'h0000_4810,
                            DIV  = 32'h0085_001A, JAL  = 32'h0C00_0100,
                            ILL  = 32'hFC00_0000, ADD  = 32'h0022_1820,
                            ADDI = 32'h2108_0001, SW   = 32'hAC43_0008,
                            JUNK = 32'hFFFF_FFFF;

    int n_chk = 0;
    int n_fail = 0;
    logic [2:0] exp_ret = 3'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One cycle's enable check; an expected pc_we advances the retire model.
    task automatic en(input string tag, input logic [9:0] exp);
        #1;
        chk(tag, {22'd0, ens}, {22'd0, exp});
        if (exp[7]) exp_ret = exp_ret + 3'd1;
    endtask

    task automatic fetch(input logic [31:0] ins, input string tag);
        bus.instr_in   = ins;
        bus.imem_ready = 1'b1;
        en({tag, ":fetch"}, E_FR);
        chk({tag, ":ret"}, {29'd0, bus.instr_retired}, {29'd0, exp_ret});
        tick();
        bus.instr_in = JUNK;
    endtask

    initial begin
        bus.instr_in   = 32'd0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b1;
        bus.br_cond    = 1'b0;

        // Reset state
        #3;
        chk("rst:ens", {22'd0, ens}, {22'd0, E_FW});
        chk("rst:ret", {29'd0, bus.instr_retired}, 32'd0);
        chk("rst:alu", {29'd0, bus.ALUControl}, 32'd4);
        chk("rst:regaddr", {27'd0, bus.RegAddr}, 32'd0);
        #9 reset = 1'b1;
        tick();

        // ori $5,$1,0x1234
        fetch(ORI, "ori");
        en("ori:dec", E_NONE);
        chk("ori:ext", {29'd0, bus.EXTControl}, 32'd0);
        tick();
        en("ori:exe", E_NONE);
        chk("ori:alu", {29'd0, bus.ALUControl}, 32'd3);
        chk("ori:alusrc", {31'd0, bus.ALUSrc}, 32'd1);
        tick();
        en("ori:wb", E_WB);
        chk("ori:regaddr", {27'd0, bus.RegAddr}, 32'd5);
        chk("ori:m2r", {29'd0, bus.Mem2Reg}, 32'd0);
        chk("ori:npc", {29'd0, bus.NPCControl}, 32'd0);
        tick();

        // lw $7,4($2) with three data-memory wait cycles
        fetch(LW, "lw");
        en("lw:dec", E_NONE);
        chk("lw:ext", {29'd0, bus.EXTControl}, 32'd1);
        tick();
        en("lw:exe", E_NONE);
        tick();
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en("lw:memwait", E_MR);
            tick();
        end
        bus.dmem_ready = 1'b1;
        en("lw:memrdy", E_MR);
        tick();
        en("lw:wb", E_WB);
        chk("lw:m2r", {29'd0, bus.Mem2Reg}, 32'd1);
        chk("lw:regaddr", {27'd0, bus.RegAddr}, 32'd7);
        tick();

        // beq taken, bgtz not taken
        fetch(BEQ, "beq");
        en("beq:dec", E_NONE);
        tick();
        bus.br_cond = 1'b1;
        en("beq:exe", E_PC);
        chk("beq:npc", {29'd0, bus.NPCControl}, 32'd1);
        tick();
        fetch(BGTZ, "bgtz");
        en("bgtz:dec", E_NONE);
        tick();
        bus.br_cond = 1'b0;
        en("bgtz:exe", E_PC);
        chk("bgtz:npc", {29'd0, bus.NPCControl}, 32'd0);
        tick();

        // mult then mfhi
        fetch(MULT, "mult");
        en("mult:dec", E_NONE);
        tick();
        en("mult:exe", E_MUL);
        tick();
        for (int i = 0; i < 3; i++) begin
            en("mult:busy", E_BUSY);
            tick();
        end
        en("mult:done", E_BDONE);
        tick();
        fetch(MFHI, "mfhi");
        en("mfhi:dec", E_NONE);
        tick();
        en("mfhi:exe", E_NONE);
        tick();
        en("mfhi:wb", E_WB);
        chk("mfhi:m2r", {29'd0, bus.Mem2Reg}, 32'd5);
        chk("mfhi:regaddr", {27'd0, bus.RegAddr}, 32'd9);
        tick();

        // div with DIV_LAT=9
        fetch(DIV, "div");
        en("div:dec", E_NONE);
        tick();
        en("div:exe", E_DIV);
        tick();
        for (int i = 0; i < 8; i++) begin
            en("div:busy", E_BUSY);
            tick();
        end
        en("div:done", E_BDONE);
        tick();

        // jal then an illegal opcode
        fetch(JAL, "jal");
        en("jal:dec", E_NONE);
        tick();
        en("jal:exe", E_WB);
        chk("jal:regaddr", {27'd0, bus.RegAddr}, 32'd31);
        chk("jal:m2r", {29'd0, bus.Mem2Reg}, 32'd3);
        chk("jal:npc", {29'd0, bus.NPCControl}, 32'd2);
        tick();
        fetch(ILL, "ill");
        en("ill:dec", E_ILL);
        chk("ill:npc", {29'd0, bus.NPCControl}, 32'd0);
        tick();

        // add $3,$1,$2
        fetch(ADD, "add");
        en("add:dec", E_NONE);
        tick();
        en("add:exe", E_NONE);
        chk("add:alu", {29'd0, bus.ALUControl}, 32'd0);
        chk("add:alusrc", {31'd0, bus.ALUSrc}, 32'd0);
        tick();
        en("add:wb", E_WB);
        chk("add:regaddr", {27'd0, bus.RegAddr}, 32'd3);
        tick();

        // Reset while idle in FETCH clears the counter
        reset = 1'b0;
        #1;
        chk("rst2:ret", {29'd0, bus.instr_retired}, 32'd0);
        tick();
        reset = 1'b1;
        exp_ret = 3'd0;

        // Nine addi: the 3-bit counter wraps to 1
        for (int k = 0; k < 9; k++) begin
            fetch(ADDI, "addi");
            en("addi:dec", E_NONE);
            tick();
            en("addi:exe", E_NONE);
            tick();
            en("addi:wb", E_WB);
            tick();
        end
        #1;
        chk("wrap:ret", {29'd0, bus.instr_retired}, 32'd1);

        // sw with zero-wait memory
        fetch(SW, "sw");
        en("sw:dec", E_NONE);
        tick();
        en("sw:exe", E_NONE);
        tick();
        en("sw:mem", E_SWR);
        tick();

        // sw abandoned by reset during MEM
        fetch(SW, "sw2");
        en("sw2:dec", E_NONE);
        tick();
        en("sw2:exe", E_NONE);
        tick();
        bus.dmem_ready = 1'b0;
        en("sw2:mem", E_MW);
        bus.imem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("sw2:rst_ens", {22'd0, ens}, {22'd0, E_FW});
        chk("sw2:rst_ret", {29'd0, bus.instr_retired}, 32'd0);
        chk("sw2:rst_alu", {29'd0, bus.ALUControl}, 32'd4);
        tick();
        reset = 1'b1;
        exp_ret = 3'd0;
        bus.dmem_ready = 1'b1;
        fetch(ORI, "ori2");
        en("ori2:dec", E_NONE);
        tick();
        en("ori2:exe", E_NONE);
        tick();
        en("ori2:wb", E_WB);
        tick();
        #1;
        chk("ori2:ret", {29'd0, bus.instr_retired}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
